serial_tx: RTL



---
 rtl/serial_pkg.sv | 30 +++
 rtl/serial_fifo.sv | 61 ++++++
 rtl/serial_tx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the Raspberry Pi UART link (serial_tx / serial_rx).
// Build option: SERIAL_TX_PARITY_EN adds the PARITY state to the frame FSM encoding.
package serial_pkg;

    localparam int unsigned DEFAULT_CLK_DIV = 868;   // 100 MHz / 115200 baud
    localparam int unsigned DATA_BITS       = 8;

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

    // Even parity over a data word: XOR of all bits.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/serial_fifo.sv
// serial_fifo: synchronous FIFO with registered full/empty flags.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module serial_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_next;
    logic [AW:0]      rd_ptr_next;
    logic             push;
    logic             pull;

    // Requests are qualified by the registered flags, so a write while full is
    // dropped even if a read frees a slot in the same cycle.
    assign push        = wr && !full;
    assign pull        = rd && !empty;
    assign wr_ptr_next = push ? wr_ptr + 1'b1 : wr_ptr;
    assign rd_ptr_next = pull ? rd_ptr + 1'b1 : rd_ptr;

    // Head of queue is visible combinationally so the consumer can pop and use it in one cycle.
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer and flag registers; flags are computed from the next pointers so
    // they describe the occupancy after the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            full   <= (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                      (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
            empty  <= (wr_ptr_next == rd_ptr_next);
        end
    end

    // Storage array write port; contents are not reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: UART transmitter for the stepper controller's Raspberry Pi link.
// Bytes are queued in serial_fifo and sent LSB first, 8N1 by default.
// Build option: define SERIAL_TX_PARITY_EN for 8E1 framing (extra even-parity bit).
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_byte,
    input  logic       tx_wr,
    output logic       tx_full,
    output logic       tx_idle,
    output logic       overflow,
    output logic       tx
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_BIT    = 3'(DATA_BITS - 1);

    state_t               state;
    state_t               state_next;
    logic [15:0]          baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_empty;
    logic                 pop;
    logic                 bit_done;
    logic                 tx_next;
`ifdef SERIAL_TX_PARITY_EN
    logic                 parity_bit;
`endif

    serial_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (tx_wr),
        .wr_data (tx_byte),
        .rd      (pop),
        .rd_data (fifo_data),
        .full    (tx_full),
        .empty   (fifo_empty)
    );

    assign bit_done = (baud_cnt == 16'd0);

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, FIFO pop and line level for the current bit period.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_next    = 1'b1;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (bit_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_next = shift[0];
                if (bit_done && (bit_cnt == LAST_BIT)) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                tx_next = parity_bit;
                if (bit_done) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                tx_next = 1'b1;
                if (bit_done) begin
                    // Chain straight into the next start bit when more bytes are waiting.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Baud and bit counters: reloaded on every bit boundary so each bit is exactly CLK_DIV clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= BAUD_RELOAD;
            bit_cnt  <= 3'd0;
        end else begin
            if (state == IDLE || bit_done) begin
                baud_cnt <= BAUD_RELOAD;
            end else begin
                baud_cnt <= baud_cnt - 16'd1;
            end
            if (state != DATA) begin
                bit_cnt <= 3'd0;
            end else if (bit_done) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // Shift register (and parity) loaded on pop, shifted right at the end of each data bit.
    always_ff @(posedge clk) begin
        if (pop) begin
            shift <= fifo_data;
        end else if (state == DATA && bit_done) begin
            shift <= {1'b0, shift[DATA_BITS-1:1]};
        end
`ifdef SERIAL_TX_PARITY_EN
        if (pop) begin
            parity_bit <= even_parity(fifo_data);
        end
`endif
    end

    // Registered outputs; tx lags the FSM by one clock, uniformly for every bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx       <= 1'b1;
            tx_idle  <= 1'b1;
            overflow <= 1'b0;
        end else begin
            tx       <= tx_next;
            tx_idle  <= (state == IDLE) && fifo_empty;
            overflow <= overflow | (tx_wr & tx_full);
        end
    end

endmodule
